// File: rtl/kulisch_acc_drain_if.sv
// Output stream of the Kulisch drain: one FP32 element per handshake with tile coordinates.
interface kulisch_acc_drain_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/kulisch_acc_drain.sv
// Holds the carry-save Kulisch tile across k MMA steps, then resolves, rounds to FP32
// and streams the tile out row-major.
module kulisch_acc_drain #(
  parameter int unsigned NUM    = 4,
  parameter int unsigned AWIDTH = 92,
  parameter int unsigned FWIDTH = 48,
  parameter int unsigned KWIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [KWIDTH-1:0]                    k_steps,
  input  logic                                 step_valid,
  input  logic [NUM-1:0][NUM-1:0][AWIDTH-1:0] gemm_sum_in,
  input  logic [NUM-1:0][NUM-1:0][AWIDTH-1:0] gemm_carry_in,
  output logic [NUM-1:0][NUM-1:0][AWIDTH-1:0] acc_sum_out,
  output logic [NUM-1:0][NUM-1:0][AWIDTH-1:0] acc_carry_out,
  output logic                                 acc_valid_out,
  kulisch_acc_drain_if.master                  ostream,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned RW    = $clog2(NUM);
  localparam int unsigned IW    = 2 * RW + 1;
  localparam int unsigned PW    = $clog2(AWIDTH);
  localparam int unsigned NELEM = NUM * NUM;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e                              state_q, state_d;
  logic [KWIDTH-1:0]                   cnt_q, cnt_d;
  logic [NUM-1:0][NUM-1:0][AWIDTH-1:0] sum_q, sum_d, carry_q, carry_d;
  logic                                acc_valid_q, acc_valid_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic                                ov_q, ov_d, last_q, last_d, done_q, done_d;
  logic [31:0]                         data_q, data_d;
  logic [RW-1:0]                       row_q, row_d, col_q, col_d;

  logic [RW-1:0]     idx_row, idx_col;
  logic [AWIDTH-1:0] elem_v, mag, norm;
  logic [PW-1:0]     lead;
  logic              guard, sticky;
  logic [23:0]       mant;
  logic [7:0]        expo;
  logic [31:0]       fp;

  assign idx_row = idx_q[2*RW-1:RW];
  assign idx_col = idx_q[RW-1:0];

  // Element conversion: resolve carry-save, take magnitude, normalise, round-to-nearest-even.
  always_comb begin
    elem_v = sum_q[idx_row][idx_col] + carry_q[idx_row][idx_col];
    mag    = elem_v[AWIDTH-1] ? (~elem_v) + AWIDTH'(1) : elem_v;
    lead   = '0;
    for (int unsigned i = 0; i < AWIDTH; i++) begin
      if (mag[i]) lead = PW'(i);
    end
    norm   = mag << (PW'(AWIDTH - 1) - lead);
    guard  = norm[AWIDTH-25];
    sticky = |norm[AWIDTH-26:0];
    mant   = {1'b0, norm[AWIDTH-2 -: 23]} + 24'(guard & (sticky | norm[AWIDTH-24]));
    expo   = 8'(lead) + 8'(127 - FWIDTH) + 8'(mant[23]);
    // A rounding carry leaves mant[22:0] all zero, so only the exponent needs the bump.
    fp     = norm[AWIDTH-1] ? {elem_v[AWIDTH-1], expo, mant[22:0]} : 32'h0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    acc_valid_d = acc_valid_q;
    idx_d       = idx_q;
    ov_d        = ov_q;
    data_d      = data_q;
    row_d       = row_q;
    col_d       = col_q;
    last_d      = last_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && k_steps != '0) begin
          state_d     = StAccum;
          cnt_d       = k_steps;
          sum_d       = '0;
          carry_d     = '0;
          acc_valid_d = 1'b0;
        end
      end
      StAccum: begin
        if (step_valid) begin
          sum_d       = gemm_sum_in;
          carry_d     = gemm_carry_in;
          acc_valid_d = 1'b1;
          cnt_d       = cnt_q - KWIDTH'(1);
          if (cnt_q == KWIDTH'(1)) begin
            state_d = StDrain;
            idx_d   = '0;
          end
        end
      end
      StDrain: begin
        if (ov_q && ostream.out_ready && last_q) begin
          ov_d    = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if ((!ov_q || ostream.out_ready) && idx_q != IW'(NELEM)) begin
          ov_d   = 1'b1;
          data_d = fp;
          row_d  = idx_row;
          col_d  = idx_col;
          last_d = (idx_q == IW'(NELEM - 1));
          idx_d  = idx_q + IW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      acc_valid_q <= 1'b0;
      idx_q       <= '0;
      ov_q        <= 1'b0;
      data_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      acc_valid_q <= acc_valid_d;
      idx_q       <= idx_d;
      ov_q        <= ov_d;
      data_q      <= data_d;
      row_q       <= row_d;
      col_q       <= col_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign acc_sum_out       = sum_q;
  assign acc_carry_out     = carry_q;
  assign acc_valid_out     = acc_valid_q;
  assign ostream.out_valid = ov_q;
  assign ostream.out_data  = data_q;
  assign ostream.out_row   = row_q;
  assign ostream.out_col   = col_q;
  assign ostream.out_last  = last_q;
  assign busy              = (state_q != StIdle);
  assign done              = done_q;

endmodule
